// File: rtl/nvious_pkg.sv
// nvious_pkg: shared types and constants for the nvious_digits block.
// Holds the FSM state type, the 7-segment encodings for 0..9, the
// 16-step countdown glyph sequence and a rectangle hit-test helper.
// Segment word layout: bit7 dp, bits6..0 segments g..a.
package nvious_pkg;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_LIVE  = 1'b1
  } state_t;

  localparam logic [7:0] GLYPH_DP    = 8'h80;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  // 9 leaves segment d dark (six-segment style nine).
  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67
  };

  localparam logic [7:0] COUNT_GLYPH [16] = '{
    SEG_DIGIT[9], SEG_DIGIT[8], SEG_DIGIT[7], SEG_DIGIT[6],
    SEG_DIGIT[5], SEG_DIGIT[4], SEG_DIGIT[3], SEG_DIGIT[2],
    SEG_DIGIT[1], SEG_DIGIT[0],
    GLYPH_DP, GLYPH_BLANK, GLYPH_DP, GLYPH_BLANK, GLYPH_DP, GLYPH_BLANK
  };

  // Half-open rectangle test; callers keep all operands 11-bit so the
  // upper-bound sums never wrap for on-screen coordinates.
  function automatic logic in_box(input logic [10:0] x, input logic [10:0] y,
                                  input logic [10:0] x0, input logic [10:0] y0,
                                  input logic [10:0] w, input logic [10:0] h);
    return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
  endfunction

endpackage

// File: rtl/nvious_seg_hit.sv
// nvious_seg_hit: combinational hit vector for one digit box.
// hit[6:0] = segments g..a, hit[7] = decimal point square at lower right.
module nvious_seg_hit
  import nvious_pkg::*;
#(
  parameter int BX    = 192,
  parameter int BY    = 8,
  parameter int SEG_L = 48,
  parameter int SEG_T = 8
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic [7:0]  hit
);

  localparam logic [10:0] BXL = 11'(BX);
  localparam logic [10:0] BYL = 11'(BY);
  localparam logic [10:0] L   = 11'(SEG_L);
  localparam logic [10:0] T   = 11'(SEG_T);

  // Standard layout: horizontal bars a/g/d, vertical bars f/b (upper) and e/c (lower).
  always_comb begin
    hit    = '0;
    hit[0] = in_box(x, y, BXL + T,         BYL,                 L, T); // a
    hit[1] = in_box(x, y, BXL + T + L,     BYL + T,             T, L); // b
    hit[2] = in_box(x, y, BXL + T + L,     BYL + 2*T + L,       T, L); // c
    hit[3] = in_box(x, y, BXL + T,         BYL + 2*T + 2*L,     L, T); // d
    hit[4] = in_box(x, y, BXL,             BYL + 2*T + L,       T, L); // e
    hit[5] = in_box(x, y, BXL,             BYL + T,             T, L); // f
    hit[6] = in_box(x, y, BXL + T,         BYL + T + L,         L, T); // g
    hit[7] = in_box(x, y, BXL + 2*T + L,   BYL + 2*T + 2*L,     T, T); // dp
  end

endmodule

// File: rtl/nvious_digits.sv
// nvious_digits: 7-segment digit overlay for a raster display.
// Counts down through a fixed glyph sequence (COUNT) until the first
// nonzero seg_data word arrives, then shows host data (LIVE) updated
// once per frame from a shadow register so a frame never tears.
// Optional build macro NVIOUS_DIGITS_BLINK_EN: in LIVE, bit7 of a digit
// becomes a blink enable (dp not drawn) instead of the decimal point.
// Handshake: seg_ready is always 1, so every cycle with seg_valid high
// is a transfer of seg_data into the shadow register.
module nvious_digits
  import nvious_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int FRAMES_PER_STEP = 64,
  parameter int X0              = 192,
  parameter int Y0              = 8,
  parameter int SEG_L           = 48,
  parameter int SEG_T           = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              hpos,
  input  logic [9:0]              vpos,
  input  logic                    display_on,
  input  logic                    vsync,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  output logic                    pix_on,
  output logic                    live
);

  localparam int         PITCH    = SEG_L + 3*SEG_T;
  localparam logic [7:0] FPS_LAST = 8'(FRAMES_PER_STEP - 1);

  state_t                  state;
  state_t                  state_next;
  logic                    vsync_q;
  logic                    frame_tick;
  logic [3:0]              step;
  logic [7:0]              fcnt;
  logic [8*NUM_DIGITS-1:0] shadow;
  logic [8*NUM_DIGITS-1:0] disp;
  logic [7:0]              word [NUM_DIGITS];
  logic [7:0]              hit  [NUM_DIGITS];
  logic                    pix_next;
  logic [10:0]             x;
  logic [10:0]             y;

  assign seg_ready  = 1'b1;
  assign live       = (state == ST_LIVE);
  assign frame_tick = vsync & ~vsync_q;
  assign x          = {1'b0, hpos};
  assign y          = {1'b0, vpos};

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      nvious_seg_hit #(
        .BX    (X0 + k*PITCH),
        .BY    (Y0),
        .SEG_L (SEG_L),
        .SEG_T (SEG_T)
      ) u_hit (
        .x   (x),
        .y   (y),
        .hit (hit[k])
      );
    end
  endgenerate

  // Next state: the first nonzero handshake in COUNT commits to LIVE for good.
  always_comb begin
    state_next = state;
    if (state == ST_COUNT && seg_valid && (|seg_data)) state_next = ST_LIVE;
  end

  // State, frame/step counters, shadow and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_COUNT;
      vsync_q <= 1'b0;
      step    <= '0;
      fcnt    <= '0;
      shadow  <= '0;
      disp    <= '0;
    end else begin
      vsync_q <= vsync;
      state   <= state_next;
      if (seg_valid) shadow <= seg_data;
      if (frame_tick) begin
        if (state == ST_COUNT) begin
          if (fcnt == FPS_LAST) begin
            fcnt <= '0;
            step <= step + 4'd1;
          end else begin
            fcnt <= fcnt + 8'd1;
          end
        end else begin
          // Free-running in LIVE; disp picks up the pre-handshake shadow.
          fcnt <= fcnt + 8'd1;
          disp <= shadow;
        end
      end
    end
  end

  // Per-digit effective segment word and the combined pixel hit.
  always_comb begin
    pix_next = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      word[i] = (state == ST_LIVE) ? disp[8*i +: 8] : COUNT_GLYPH[step];
`ifdef NVIOUS_DIGITS_BLINK_EN
      if (state == ST_LIVE) begin
        if (word[i][7] && fcnt[5]) word[i] = 8'h00;
        word[i][7] = 1'b0;
      end
`endif
      pix_next = pix_next | (|(word[i] & hit[i]));
    end
    pix_next = pix_next & display_on;
  end

  // Registered pixel output, one clock behind hpos/vpos/display_on.
  always_ff @(posedge clk) begin
    if (!rst_n) pix_on <= 1'b0;
    else        pix_on <= pix_next;
  end

endmodule
